// File: rtl/vc_trace_line_serializer.sv
// Byte-stream serializer for packed line-trace buffers: an optional hex line-number
// prefix, the trace characters from the top slot downward, then an optional newline.
module vc_trace_line_serializer #(
  parameter int NCHARS    = 512,
  parameter bit PREFIX_EN = 1'b1,
  parameter bit APPEND_NL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [NCHARS*8-1:0] in_msg,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [7:0]          out_msg,
  output logic                busy,
  output logic [15:0]         line_count
);

  localparam int PW = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam logic [16:0] TOP = 17'(NCHARS - 1);

  typedef enum logic [1:0] {IDLE, PREFIX, BODY, NEWLINE} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [2:0]            pcnt_q, pcnt_d;
  logic [15:0]           count_q, count_d;
  logic [NCHARS*8-1:0]   line_q;
  logic                  load;
  logic                  fire;
  logic [16:0]           line_lo;
  logic                  line_empty;
  logic                  in_empty;

  // Chars 0 and 1 hold the index field, so the lowest emitted slot is never below 2.
  function automatic logic [16:0] lo_of(input logic [15:0] idx);
    return (idx <= 16'd1) ? 17'd2 : ({1'b0, idx} + 17'd1);
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign line_lo    = lo_of(line_q[15:0]);
  assign line_empty = (line_lo > TOP);
  assign in_empty   = (lo_of(in_msg[15:0]) > TOP);

  assign in_rdy     = (state_q == IDLE);
  assign out_val    = (state_q != IDLE);
  assign busy       = out_val;
  assign fire       = out_val && out_rdy;
  assign line_count = count_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pcnt_d  = pcnt_q;
    count_d = count_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_val) begin
          load   = 1'b1;
          ptr_d  = PW'(NCHARS - 1);
          pcnt_d = 3'd0;
          if (PREFIX_EN)     state_d = PREFIX;
          else if (!in_empty) state_d = BODY;
          else if (APPEND_NL) state_d = NEWLINE;
          else               count_d = count_q + 16'd1;
        end
      end
      PREFIX: begin
        if (fire) begin
          if (pcnt_q == 3'd5) begin
            if (!line_empty)    state_d = BODY;
            else if (APPEND_NL) state_d = NEWLINE;
            else begin
              state_d = IDLE;
              count_d = count_q + 16'd1;
            end
          end else begin
            pcnt_d = pcnt_q + 3'd1;
          end
        end
      end
      BODY: begin
        if (fire) begin
          if ({{(17-PW){1'b0}}, ptr_q} == line_lo) begin
            if (APPEND_NL) state_d = NEWLINE;
            else begin
              state_d = IDLE;
              count_d = count_q + 16'd1;
            end
          end else begin
            ptr_d = ptr_q - PW'(1);
          end
        end
      end
      NEWLINE: begin
        if (fire) begin
          state_d = IDLE;
          count_d = count_q + 16'd1;
        end
      end
    endcase
  end

  // Output byte is a pure function of registered state, never of out_rdy.
  always_comb begin
    out_msg = 8'h00;
    case (state_q)
      PREFIX: begin
        case (pcnt_q)
          3'd0:    out_msg = hex_char(count_q[15:12]);
          3'd1:    out_msg = hex_char(count_q[11:8]);
          3'd2:    out_msg = hex_char(count_q[7:4]);
          3'd3:    out_msg = hex_char(count_q[3:0]);
          3'd4:    out_msg = 8'h3A;
          default: out_msg = 8'h20;
        endcase
      end
      BODY:    out_msg = line_q[{ptr_q, 3'b000} +: 8];
      NEWLINE: out_msg = 8'h0A;
      default: out_msg = 8'h00;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      pcnt_q  <= '0;
      count_q <= '0;
      // NOTE: the wide line buffer is reset too, so a reset never leaves stale trace data visible.
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      if (load) line_q <= in_msg;
    end
  end

endmodule

// File: tb/tb_vc_trace_line_serializer.sv
// Bench for vc_trace_line_serializer: a full-featured instance (prefix + newline) and
// a bare instance (no prefix, no newline), checked against a queue-based line model.
module tb_vc_trace_line_serializer;

  localparam int NCHARS = 512;
  localparam int NB     = NCHARS * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val_a, in_val_b;
  logic [NB-1:0] in_msg;
  logic          out_rdy;

  logic          in_rdy_a, out_val_a, busy_a;
  logic [7:0]    out_msg_a;
  logic [15:0]   line_count_a;
  logic          in_rdy_b, out_val_b, busy_b;
  logic [7:0]    out_msg_b;
  logic [15:0]   line_count_b;

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;  // 0: always ready, 1: pattern 1,0,0 repeating, 2: random

  byte cap_a[$];
  byte cap_b[$];
  byte exp_q[$];
  logic [15:0] exp_cnt_a = 16'd0;
  logic [15:0] exp_cnt_b = 16'd0;

  always #5 clk = ~clk;

  vc_trace_line_serializer #(.NCHARS(NCHARS), .PREFIX_EN(1'b1), .APPEND_NL(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .in_val(in_val_a), .in_rdy(in_rdy_a), .in_msg(in_msg),
    .out_val(out_val_a), .out_rdy(out_rdy), .out_msg(out_msg_a),
    .busy(busy_a), .line_count(line_count_a)
  );

  vc_trace_line_serializer #(.NCHARS(NCHARS), .PREFIX_EN(1'b0), .APPEND_NL(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .in_val(in_val_b), .in_rdy(in_rdy_b), .in_msg(in_msg),
    .out_val(out_val_b), .out_rdy(out_rdy), .out_msg(out_msg_b),
    .busy(busy_b), .line_count(line_count_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Sink ready driver.
  initial begin
    int phase = 0;
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = ((phase % 3) == 0);
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      phase++;
    end
  end

  // Byte capture and stall-hold monitor, sampled mid-cycle.
  initial begin
    logic       stall_a = 1'b0;
    logic [7:0] stall_msg_a = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (stall_a)
          check("stall hold", {23'd0, out_val_a, out_msg_a}, {23'd0, 1'b1, stall_msg_a});
        if (out_val_a && out_rdy) cap_a.push_back(out_msg_a);
        if (out_val_b && out_rdy) cap_b.push_back(out_msg_b);
        stall_a     = out_val_a && !out_rdy;
        stall_msg_a = out_msg_a;
      end else begin
        stall_a = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [NB-1:0] rand_buf();
    logic [NB-1:0] r;
    for (int w = 0; w < NB / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [NB-1:0] mk_line(input string s, input int idx);
    logic [NB-1:0] m;
    m = rand_buf();
    for (int i = 0; i < s.len(); i++) m[(NCHARS-1-i)*8 +: 8] = s[i];
    m[15:0] = 16'(idx);
    return m;
  endfunction

  // Reference: the byte list a line should produce, straight from the buffer-format rules.
  task automatic model_line(input logic [NB-1:0] m, input logic [15:0] cnt,
                            input bit pfx, input bit nl);
    int    idx;
    int    lo;
    string hx;
    exp_q.delete();
    if (pfx) begin
      hx = $sformatf("%04h: ", cnt);
      for (int i = 0; i < hx.len(); i++) exp_q.push_back(hx[i]);
    end
    idx = int'(m[15:0]);
    lo  = (idx + 1 > 2) ? idx + 1 : 2;
    for (int k = NCHARS - 1; k >= lo; k--) exp_q.push_back(m[k*8 +: 8]);
    if (nl) exp_q.push_back(8'h0A);
  endtask

  task automatic set_expect(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Send one line to instance sel (0=a, 1=b), wait for it to drain, compare against exp_q.
  task automatic do_line(input int sel, input logic [NB-1:0] m, input string name);
    int  cyc;
    int  n;
    int  bad_at;
    bit  idle;
    byte b;
    if (sel == 0) cap_a.delete(); else cap_b.delete();
    in_msg = m;
    if (sel == 0) in_val_a = 1'b1; else in_val_b = 1'b1;
    @(posedge clk);
    #1;
    in_val_a = 1'b0;
    in_val_b = 1'b0;
    in_msg   = rand_buf();
    cyc  = 0;
    idle = 1'b0;
    while (!idle && cyc < 4 * exp_q.size() + 50) begin
      @(negedge clk);
      cyc++;
      idle = (sel == 0) ? (in_rdy_a && !busy_a) : (in_rdy_b && !busy_b);
    end
    check({name, " done"}, 32'(idle), 32'd1);
    if (rdy_mode == 0) check({name, " cycles"}, cyc, exp_q.size() + 1);
    n = (sel == 0) ? cap_a.size() : cap_b.size();
    check({name, " len"}, n, exp_q.size());
    bad_at = -1;
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      b = (sel == 0) ? cap_a[i] : cap_b[i];
      if (b !== exp_q[i] && bad_at < 0) bad_at = i;
    end
    check({name, " first bad byte"}, bad_at, -1);
    if (sel == 0) begin
      exp_cnt_a = exp_cnt_a + 16'd1;
      check({name, " count"}, {16'd0, line_count_a}, {16'd0, exp_cnt_a});
    end else begin
      exp_cnt_b = exp_cnt_b + 16'd1;
      check({name, " count"}, {16'd0, line_count_b}, {16'd0, exp_cnt_b});
    end
  endtask

  typedef struct {
    string body;
    int    idx;
    string want;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [NB-1:0] m;
    int            r;
    int            idx;

    vecs[0] = '{"ab",  509, "0000: ab\n"};
    vecs[1] = '{"",    511, "0001: \n"};
    vecs[2] = '{"xyz", 508, "0002: xyz\n"};
    vecs[3] = '{"q",   600, "0003: \n"};
    vecs[4] = '{"k",   510, "0004: k\n"};
    vecs[5] = '{"Hi!", 508, "0005: Hi!\n"};

    reset    = 1'b0;
    in_val_a = 1'b0;
    in_val_b = 1'b0;
    in_msg   = '0;

    @(negedge clk);
    check("reset in_rdy",   32'(in_rdy_a),  32'd1);
    check("reset out_val",  32'(out_val_a), 32'd0);
    check("reset out_msg",  32'(out_msg_a), 32'd0);
    check("reset busy",     32'(busy_a),    32'd0);
    check("reset count",    32'(line_count_a), 32'd0);
    check("reset b count",  32'(line_count_b), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven lines on the full-featured instance, sink always ready.
    rdy_mode = 0;
    foreach (vecs[i]) begin
      set_expect(vecs[i].want);
      do_line(0, mk_line(vecs[i].body, vecs[i].idx), $sformatf("vec%0d", i));
    end

    // Stalling sink: same bytes, held steady while out_rdy is low.
    rdy_mode = 1;
    m = mk_line("ab", 509);
    model_line(m, exp_cnt_a, 1'b1, 1'b1);
    do_line(0, m, "stall ab");

    // Full buffer, idx=0: chars 511..2.
    rdy_mode = 0;
    m = rand_buf();
    m[15:0] = 16'd0;
    model_line(m, exp_cnt_a, 1'b1, 1'b1);
    do_line(0, m, "full idx0");

    // Empty line on the bare instance: no bytes at all.
    set_expect("");
    do_line(1, mk_line("", 511), "bare empty");

    // Randomized lines on both instances with a random sink.
    rdy_mode = 2;
    for (int t = 0; t < 30; t++) begin
      m = rand_buf();
      r = $urandom_range(0, 9);
      if (r == 0)      idx = $urandom_range(0, 3);
      else if (r == 1) idx = $urandom_range(0, 65535);
      else             idx = $urandom_range(480, 512);
      m[15:0] = 16'(idx);
      if (r[0]) m[(NCHARS-2)*8 +: 8] = 8'h00;
      if (t % 2 == 0) begin
        model_line(m, exp_cnt_a, 1'b1, 1'b1);
        do_line(0, m, $sformatf("rand a%0d", t));
      end else begin
        model_line(m, exp_cnt_b, 1'b0, 1'b0);
        do_line(1, m, $sformatf("rand b%0d", t));
      end
    end

    // Reset pulse in the middle of a long body.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    m = rand_buf();
    m[15:0] = 16'd0;
    in_msg   = m;
    in_val_a = 1'b1;
    @(posedge clk);
    #1;
    in_val_a = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("midline busy", 32'(busy_a), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset out_val", 32'(out_val_a), 32'd0);
    check("midreset out_msg", 32'(out_msg_a), 32'd0);
    check("midreset busy",    32'(busy_a),    32'd0);
    check("midreset in_rdy",  32'(in_rdy_a),  32'd1);
    check("midreset count",   32'(line_count_a), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_cnt_a = 16'd0;
    exp_cnt_b = 16'd0;
    set_expect("0000: z\n");
    do_line(0, mk_line("z", 510), "after reset z");

    // Bare instance: 65535 back-to-back empty lines, then "x" wraps the count.
    @(posedge clk);
    #1;
    cap_b.delete();
    in_msg   = mk_line("", 511);
    in_val_b = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
      #1;
      in_msg[15:0] = 16'($urandom_range(511, 65535));
    end
    in_val_b = 1'b0;
    @(negedge clk);
    check("preload count",  32'(line_count_b), 32'h0000FFFF);
    check("preload in_rdy", 32'(in_rdy_b), 32'd1);
    check("preload no bytes", cap_b.size(), 32'd0);
    exp_cnt_b = 16'hFFFF;
    set_expect("x");
    do_line(1, mk_line("x", 510), "wrap x");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
